// File: rtl/div_unit.sv
// div_unit: iterative restoring signed divider for DIV; quotient -> lo, remainder -> hi.
// Optional macro DIV_UNSIGNED_EN adds an is_unsigned input selecting DIVU behaviour.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIX   = 2'd2,
    DZERO = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

`ifdef DIV_UNSIGNED_EN
  assign w_signed = ~is_unsigned;
`else
  assign w_signed = 1'b1;
`endif

  // Magnitudes are formed one bit wider so that |-2^(WIDTH-1)| survives negation.
  assign w_a_neg = w_signed & a[WIDTH-1];
  assign w_b_neg = w_signed & b[WIDTH-1];
  assign w_a_ext = {w_a_neg, a};
  assign w_b_ext = {w_b_neg, b};
  assign w_a_mag = WIDTH'(w_a_neg ? -w_a_ext : w_a_ext);
  assign w_b_mag = WIDTH'(w_b_neg ? -w_b_ext : w_b_ext);

  // One restoring step: shift remainder:quotient left, trial-subtract the divisor.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_sub   = WIDTH'(w_shift - {1'b0, r_div});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_quo      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        // DZERO is the pulse cycle of a divide-by-zero; it accepts start like IDLE.
        IDLE, DZERO: begin
          r_state <= IDLE;
          if (start) begin
            if (b == '0) begin
              r_state    <= DZERO;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_state  <= RUN;
              r_busy   <= 1'b1;
              r_quo    <= w_a_mag;
              r_div    <= w_b_mag;
              r_rem    <= '0;
              r_cnt    <= '0;
              r_sign_q <= w_a_neg ^ w_b_neg;
              r_sign_r <= w_a_neg;
            end
          end
        end
        RUN: begin
          r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_lo    <= r_sign_q ? -r_quo : r_quo;
          r_hi    <= r_sign_r ? -r_rem : r_rem;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner sequences, a vector table and random
// operands checked through an expected-result queue; DIV_UNSIGNED_EN adds DIVU cases.
module tb_div_unit;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_u;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned (is_u),
`endif
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Signed reference model using 64-bit arithmetic (truncating quotient, dividend-signed remainder).
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   m;
    longint sx;
    longint sy;
    longint q;
    longint r;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    q    = sx / sy;
    r    = sx % sy;
    m.lo = W'(q);
    m.hi = W'(r);
    m.dz = 1'b0;
    return m;
  endfunction

  // Issue one operation, push its expectation, then wait (bounded) for done and compare.
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tu, input exp_t e, input bit inject,
                        output int lat, output int nbusy);
    exp_t got;
    sb_q.push_back(e);
    a     = ta;
    b     = tbv;
    is_u  = tu;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    is_u  = 1'($urandom);
    lat   = 0;
    nbusy = 0;
    for (int c = 1; c <= 60; c++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = c;
        break;
      end
      if (inject && (c == 5 || c == 20)) begin
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      if (lat != 0) begin
        check({nm, " lo"}, lo, got.lo);
        check({nm, " hi"}, hi, got.hi);
        check({nm, " div_zero"}, W'(div_zero), W'(got.dz));
      end
    end
  endtask

  task automatic expect_no_done(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      if (done) seen++;
      tick();
    end
    check({nm, " stray done count"}, W'(seen), W'(0));
  endtask

  initial begin
    vec_t vt[12];
    exp_t e;
    int   lat;
    int   nb;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vt[0]  = '{32'd100,      32'd7,        32'd14,       32'd2};
    vt[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vt[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vt[3]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
    vt[4]  = '{32'd0,        32'd5,        32'd0,        32'd0};
    vt[5]  = '{32'd5,        32'd10,       32'd0,        32'd5};
    vt[6]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0};
    vt[7]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0};
    vt[8]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0};
    vt[9]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0};
    vt[10] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF};
    vt[11] = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF};

    reset = 1'b1;
    start = 1'b1;
    is_u  = 1'b0;
    a     = 32'd100;
    b     = 32'd7;
    tick();
    tick();
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset div_zero", W'(div_zero), W'(0));
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();

    // Basic latency and busy window.
    e = '{lo: 32'd14, hi: 32'd2, dz: 1'b0};
    run_op("100/7", 32'd100, 32'd7, 1'b0, e, 1'b0, lat, nb);
    check("100/7 done cycle", W'(lat), W'(34));
    check("100/7 busy cycles", W'(nb), W'(33));
    tick();
    check("100/7 done pulse width", W'(done), W'(0));

    // Divide-by-zero leaves hi/lo untouched and never raises busy.
    e = '{lo: 32'd14, hi: 32'd2, dz: 1'b1};
    run_op("5/0", 32'd5, 32'd0, 1'b0, e, 1'b0, lat, nb);
    check("5/0 done cycle", W'(lat), W'(1));
    check("5/0 busy cycles", W'(nb), W'(0));
    tick();
    check("5/0 done pulse width", W'(done), W'(0));
    check("5/0 div_zero pulse width", W'(div_zero), W'(0));

    // Overflow wrap, with start pulses while busy that must be ignored.
    e = '{lo: 32'h80000000, hi: 32'd0, dz: 1'b0};
    run_op("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0, e, 1'b1, lat, nb);
    check("ovf done cycle", W'(lat), W'(34));
    tick();
    expect_no_done("ovf ignored starts", 40);

    // Reset in the middle of an operation aborts it and clears hi/lo.
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", W'(busy), W'(0));
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    check("abort done", W'(done), W'(0));
    expect_no_done("abort", 40);
    e = '{lo: 32'd3, hi: 32'd0, dz: 1'b0};
    run_op("9/3", 32'd9, 32'd3, 1'b0, e, 1'b0, lat, nb);
    check("9/3 done cycle", W'(lat), W'(34));
    tick();

    for (int i = 0; i < 12; i++) begin
      e = '{lo: vt[i].lo, hi: vt[i].hi, dz: 1'b0};
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, 1'b0, e, 1'b0, lat, nb);
      check($sformatf("vec%0d latency", i), W'(lat), W'(34));
      tick();
    end

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd3;
      e = model(ra, rb);
      run_op($sformatf("rand%0d", i), ra, rb, 1'b0, e, 1'b0, lat, nb);
      tick();
    end

`ifdef DIV_UNSIGNED_EN
    e = '{lo: 32'h7FFFFFFF, hi: 32'd1, dz: 1'b0};
    run_op("divu", 32'hFFFFFFFF, 32'd2, 1'b1, e, 1'b0, lat, nb);
    check("divu latency", W'(lat), W'(34));
    tick();
    e = '{lo: 32'd0, hi: 32'hFFFFFFFF, dz: 1'b0};
    run_op("div -1/2", 32'hFFFFFFFF, 32'd2, 1'b0, e, 1'b0, lat, nb);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
